// File: rtl/fetch_queue_pkg.sv
// Shared constants for the prefetching fetch front end: default geometry,
// reset PC, the decode-bubble NOP encoding and the sequential PC step.
package fetch_queue_pkg;

   localparam int          FQ_DEPTH    = 4;
   localparam int          FQ_XLEN     = 32;
   localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INS_NOP     = 32'h0000_0013;
   localparam int          PC_STEP     = 4;

   // Used at elaboration to reject FIFO depths that break pointer wrap-around.
   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the redirect, instruction-memory and decode handshakes around fetch_queue.
// The master modport is the fetch_queue side; slave is memory/decode/branch unit.
interface fetch_queue_if #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
);

   logic                    redirect;
   logic [XLEN-1:0]         redirect_pc;
   logic                    imem_req_valid;
   logic                    imem_req_ready;
   logic [XLEN-1:0]         imem_req_addr;
   logic                    imem_rsp_valid;
   logic [XLEN-1:0]         imem_rsp_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [XLEN-1:0]         out_ins;
   logic [$clog2(DEPTH):0]  count;

   modport master (
      input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_ins, count
   );

   modport slave (
      output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_ins, count
   );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; head is read straight
// from storage so it only shows entries written on an earlier edge.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_clear,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty,
   output logic                   o_full
);

   localparam int              AW         = $clog2(DEPTH);
   localparam int              CW         = AW + 1;
   localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_COUNT);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   // Storage is zeroed on reset so the head reads as zero until the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch front end: issues sequential requests ahead of decode, buffers
// returned instructions with their PCs, and flushes everything on a redirect.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              DEPTH    = FQ_DEPTH,
   parameter int              XLEN     = FQ_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(FQ_RESET_PC)
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master bus
);

   localparam int            CW           = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);

   if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
   end

   logic [XLEN-1:0]   r_fetch_pc;
   logic [CW-1:0]     r_inflight;
   logic [CW-1:0]     r_drop;

   logic [2*XLEN-1:0] w_head;
   logic [CW-1:0]     w_count;
   logic              w_empty;
   logic              w_full;
   logic [XLEN-1:0]   w_pend_pc;
   logic [CW-1:0]     w_pend_count;
   logic              w_pend_empty;
   logic              w_pend_full;
   logic [CW:0]       w_credit_used;
   logic              w_req_valid;
   logic              w_req_fire;
   logic              w_rsp;
   logic              w_drop_active;
   logic              w_rsp_keep;
   logic              w_pop;
   logic              w_unused_pc_lsbs;

   // Every accepted-but-undropped request reserves a slot, so an undropped response
   // always finds room; rst_n gates the request so nothing is offered while in reset.
   assign w_credit_used = {1'b0, w_count} + {1'b0, r_inflight} - {1'b0, r_drop};
   assign w_req_valid   = rst_n && !bus.redirect && (w_credit_used < CREDIT_LIMIT);
   assign w_req_fire    = w_req_valid && bus.imem_req_ready;
   assign w_rsp         = bus.imem_rsp_valid;
   assign w_drop_active = (r_drop != '0);
   assign w_rsp_keep    = w_rsp && !bus.redirect && !w_drop_active;
   assign w_pop         = !w_empty && bus.out_ready && !bus.redirect;

   assign w_unused_pc_lsbs = ^bus.redirect_pc[1:0];

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.out_valid      = !w_empty;
   assign bus.out_pc         = w_head[2*XLEN-1:XLEN];
   assign bus.out_ins        = w_head[XLEN-1:0];
   assign bus.count          = w_count;

   // PCs of live requests wait here until their responses return in order; the
   // queue is cleared on redirect because stale responses are only counted, not paired.
   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_pend_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (bus.redirect),
      .i_push      (w_req_fire),
      .i_push_data (r_fetch_pc),
      .i_pop       (w_rsp_keep),
      .o_head      (w_pend_pc),
      .o_count     (w_pend_count),
      .o_empty     (w_pend_empty),
      .o_full      (w_pend_full)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLEN)
   ) u_ins_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (bus.redirect),
      .i_push      (w_rsp_keep),
      .i_push_data ({w_pend_pc, bus.imem_rsp_data}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );

   // A redirect turns every request still in flight (after this cycle's response)
   // into one to be discarded, and restarts fetch at the word-aligned target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
         if (bus.redirect) begin
            r_drop     <= r_inflight - CW'(w_rsp);
            r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         end else begin
            if (w_rsp && w_drop_active) begin
               r_drop <= r_drop - CW'(1);
            end
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            end
         end
      end
   end

   a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
      w_rsp |-> (r_inflight != '0));

   a_pend_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
      (w_pend_count == (r_inflight - r_drop)) && (w_pend_empty == (w_pend_count == '0))
      && !(w_pend_full && w_req_fire));

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_rsp_keep && w_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a directed vector table, hand-written
// redirect/wrap/reset sequences and randomized traffic against a queue-based model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

   fetch_queue #(
      .DEPTH    (DEPTH),
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } entry_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memreq_t;

   typedef struct {
      logic        outReady;
      logic        expReqV;
      logic [31:0] expAddr;
      logic        expOutV;
      logic [31:0] expPc;
      int          expCount;
   } vec_t;

   entry_t      mFifo[$];
   logic [31:0] mPend[$];
   int          mStale;
   logic [31:0] mFetchPc;
   memreq_t     memQ[$];
   int          cyc;
   int          lat;
   int          nVec;
   int          nMiss;
   logic        rspNow;
   vec_t        tbl[12];

   // The memory returns a fixed scramble of the address so every PC maps to a known word.
   function automatic logic [31:0] insOf(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic resetModel();
      mFifo.delete();
      mPend.delete();
      memQ.delete();
      mStale   = 0;
      mFetchPc = 32'h0000_0000;
      cyc      = 0;
   endtask

   task automatic idleInputs();
      bus.redirect       = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.out_ready      = 1'b0;
      rspNow             = 1'b0;
   endtask

   // Called at a falling edge; the memory presents its oldest due response.
   task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                input logic reqReady, input logic outReady, input logic rspEn);
      bus.redirect       = redir;
      bus.redirect_pc    = rpc;
      bus.imem_req_ready = reqReady;
      bus.out_ready      = outReady;
      rspNow             = 1'b0;
      if (rspEn && (memQ.size() > 0)) begin
         if (memQ[0].due <= cyc) rspNow = 1'b1;
      end
      bus.imem_rsp_valid = rspNow;
      bus.imem_rsp_data  = rspNow ? insOf(memQ[0].addr) : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic checkOutput();
      logic expReqV;
      expReqV = !bus.redirect && ((mFifo.size() + mPend.size()) < DEPTH);
      checkVal("req_valid", 32'(bus.imem_req_valid), 32'(expReqV));
      if (expReqV) checkVal("req_addr", bus.imem_req_addr, mFetchPc);
      checkVal("out_valid", 32'(bus.out_valid), 32'(mFifo.size() != 0));
      if (mFifo.size() != 0) begin
         checkVal("out_pc", bus.out_pc, mFifo[0].pc);
         checkVal("out_ins", bus.out_ins, mFifo[0].ins);
      end
      checkVal("count", 32'(bus.count), 32'(mFifo.size()));
   endtask

   // Commits this cycle's handshakes to the memory and the model, then clocks.
   task automatic advanceClock();
      logic        expFire;
      logic        expPop;
      logic [31:0] pc;
      int          due;
      expFire = !bus.redirect && ((mFifo.size() + mPend.size()) < DEPTH) && bus.imem_req_ready;
      expPop  = (mFifo.size() != 0) && bus.out_ready && !bus.redirect;
      if (rspNow) void'(memQ.pop_front());
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         due = cyc + lat;
         if ((memQ.size() > 0) && (memQ[$].due > due)) due = memQ[$].due;
         memQ.push_back(memreq_t'{addr: bus.imem_req_addr, due: due});
      end
      if (expPop) void'(mFifo.pop_front());
      if (bus.redirect) begin
         mStale   = mStale + mPend.size() - (rspNow ? 1 : 0);
         mPend.delete();
         mFifo.delete();
         mFetchPc = {bus.redirect_pc[31:2], 2'b00};
      end else begin
         if (rspNow) begin
            if (mStale > 0) begin
               mStale--;
            end else if (mPend.size() > 0) begin
               pc = mPend.pop_front();
               mFifo.push_back(entry_t'{pc: pc, ins: insOf(pc)});
            end
         end
         if (expFire) begin
            mPend.push_back(mFetchPc);
            mFetchPc = mFetchPc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      idleInputs();
      resetModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic modelCycle(input logic redir, input logic [31:0] rpc,
                             input logic reqReady, input logic outReady, input logic rspEn);
      applyStimulus(redir, rpc, reqReady, outReady, rspEn);
      checkOutput();
      advanceClock();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        found;
      logic        r;
      logic [31:0] rpc;
      nVec  = 0;
      nMiss = 0;
      lat   = 1;
      idleInputs();
      resetModel();
      #2;
      checkVal("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("rst_count", 32'(bus.count), 32'd0);
      checkVal("rst_out_pc", bus.out_pc, 32'd0);
      checkVal("rst_out_ins", bus.out_ins, 32'd0);

      // Back-pressure fill to DEPTH at latency 1, then release and resume at 0x10.
      tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 0};
      tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 0};
      tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1};
      tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 2};
      tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3};
      tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 4};
      tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 4};
      tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 4};
      tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3};
      tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 2};
      tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 2};
      tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 2};

      doReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, tbl[i].outReady, 1'b1);
         checkVal("tbl_req_valid", 32'(bus.imem_req_valid), 32'(tbl[i].expReqV));
         if (tbl[i].expReqV) checkVal("tbl_req_addr", bus.imem_req_addr, tbl[i].expAddr);
         checkVal("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].expOutV));
         if (tbl[i].expOutV) begin
            checkVal("tbl_out_pc", bus.out_pc, tbl[i].expPc);
            checkVal("tbl_out_ins", bus.out_ins, insOf(tbl[i].expPc));
         end
         checkVal("tbl_count", 32'(bus.count), 32'(tbl[i].expCount));
         advanceClock();
      end
      for (int i = 0; i < 10; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Latency 3 with three requests in flight, redirect to an unaligned target.
      doReset();
      lat = 3;
      for (int i = 0; i < 3; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      modelCycle(1'b1, 32'h0000_1002, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      checkVal("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
      checkVal("redir_req_addr", bus.imem_req_addr, 32'h0000_1000);
      found = 1'b0;
      for (int k = 0; (k < 20) && !found; k++) begin
         applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
         checkOutput();
         if (bus.out_valid) found = 1'b1;
         else advanceClock();
      end
      checkVal("redir_first_valid_seen", 32'(found), 32'd1);
      if (found) begin
         checkVal("redir_first_pc", bus.out_pc, 32'h0000_1000);
         checkVal("redir_first_ins", bus.out_ins, insOf(32'h0000_1000));
      end

      // Redirect coinciding with a response and a pop at latency 2.
      doReset();
      lat = 2;
      for (int i = 0; i < 5; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 32'h0000_3000, 1'b1, 1'b1, 1'b1);
      checkVal("flush_rsp_present", 32'(rspNow), 32'd1);
      checkVal("flush_head_present", 32'(bus.out_valid), 32'd1);
      advanceClock();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkVal("flush_out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("flush_count", 32'(bus.count), 32'd0);
      checkVal("flush_req_addr", bus.imem_req_addr, 32'h0000_3000);
      checkOutput();
      advanceClock();
      for (int i = 0; i < 8; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Fetch address wraps from the top of the address space to zero.
      doReset();
      lat = 1;
      modelCycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkVal("wrap_req_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
      checkOutput();
      advanceClock();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkVal("wrap_req_addr_zero", bus.imem_req_addr, 32'h0000_0000);
      checkOutput();
      advanceClock();
      for (int i = 0; i < 4; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Randomized traffic at each latency.
      doReset();
      for (int l = 1; l <= 4; l++) begin
         lat = l;
         for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            modelCycle(r, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 3) != 0));
         end
      end

      // Asynchronous reset between edges in the middle of traffic.
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      checkVal("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("async_rst_count", 32'(bus.count), 32'd0);
      checkVal("async_rst_out_pc", bus.out_pc, 32'd0);
      checkVal("async_rst_out_ins", bus.out_ins, 32'd0);
      doReset();
      lat = 1;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      checkVal("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
      checkVal("post_rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
      checkOutput();
      advanceClock();
      for (int i = 0; i < 6; i++) modelCycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
